// File: rtl/serial_pkg.sv
// serial_pkg
// Shared types and constants for the serial-input front end.
//   state_t          : serializer FSM states (IDLE, SHIFT)
//   IDLE_BIT_DEFAULT : level driven on the serial line between frames
//   frame_len()      : bits per frame for a given word width
// Optional build macro: SERIAL_PARITY_EN (adds one even-parity bit per frame)
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // With parity enabled every frame carries one extra trailing bit.
  function automatic int frame_len(input int width);
`ifdef SERIAL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer
// Accepts a parallel word over a valid/ready handshake and shifts it out
// MSB-first, one bit per clock, on x. x_valid qualifies frame bits and
// frame_done pulses with the final bit of each frame.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   din        : parallel word (sampled only on an accepted handshake)
//   din_valid  : din holds a word to send
//   din_ready  : a word can be accepted this cycle
//   x          : serial bit
//   x_valid    : x carries a frame bit this cycle
//   frame_done : one-cycle pulse on the last bit of a frame
// Optional build macro: SERIAL_PARITY_EN -- appends an even-parity bit
// (XOR of the accepted word) after the data bits.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CW        = $clog2(WIDTH + 1);

  state_t           state;
  // Holds the bits still waiting to be sent; the bit currently on x has
  // already been moved into the x register.
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             next_bit;

`ifdef SERIAL_PARITY_EN
  logic             par;
`endif

  assign load = din_valid && din_ready;

  // Bit to present after the next edge. With parity, the cycle after the
  // last data bit (counter at 1) carries the stored parity instead.
  always_comb begin
    next_bit = shreg[WIDTH-1];
`ifdef SERIAL_PARITY_EN
    if (cnt == CW'(1)) begin
      next_bit = par;
    end
`endif
  end

  // Single FSM process. din_ready is high only in IDLE and in the last-bit
  // cycle, so a handshake in the last-bit cycle chains the next frame with
  // no gap. Each SHIFT edge with cnt != 0 shifts out one more bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
      din_ready  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par        <= 1'b0;
`endif
    end else if (load) begin
      state      <= SHIFT;
      shreg      <= {din[WIDTH-2:0], 1'b0};
      cnt        <= CW'(FRAME_LEN - 1);
      x          <= din[WIDTH-1];
      x_valid    <= 1'b1;
      frame_done <= 1'b0;
      din_ready  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par        <= ^din;
`endif
    end else if (state == SHIFT && cnt != '0) begin
      shreg      <= shreg << 1;
      cnt        <= cnt - CW'(1);
      x          <= next_bit;
      x_valid    <= 1'b1;
      frame_done <= (cnt == CW'(1));
      din_ready  <= (cnt == CW'(1));
    end else begin
      state      <= IDLE;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
      din_ready  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
// Scoreboard bench for bit_serializer: each accepted word pushes its
// expected bit sequence (plus last-bit flag) onto a queue; a negedge monitor
// pops and compares every x_valid cycle, and checks idle levels and
// din_ready otherwise. Honors SERIAL_PARITY_EN when defined.
module tb_bit_serializer;

  localparam int   W        = 8;
  localparam logic IDLE_LVL = 1'b0;
`ifdef SERIAL_PARITY_EN
  localparam int   FLEN     = W + 1;
`else
  localparam int   FLEN     = W;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         x;
  logic         x_valid;
  logic         frame_done;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   edgesSinceRelease;
  int   runLen;
  int   lastRun;
  int   doneCount;

  bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_LVL)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clock edges since reset release; din_ready is only expected
  // high once at least one edge has passed.
  always @(posedge clk or negedge rst) begin
    if (!rst) edgesSinceRelease <= 0;
    else      edgesSinceRelease <= edgesSinceRelease + 1;
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_t e;
      logic expReady;
      if (x_valid === 1'b1) begin
        runLen++;
        if (frame_done === 1'b1) doneCount++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_bit: x_valid=%b with empty scoreboard, required x_valid=0", x_valid);
          expReady = 1'b1;
        end else begin
          e = sb.pop_front();
          if (x !== e.b || frame_done !== e.last) begin
            miscompares++;
            $display("[TB] FAIL frame_bit: x=%b frame_done=%b, required x=%b frame_done=%b",
                     x, frame_done, e.b, e.last);
          end
          expReady = e.last;
        end
      end else begin
        if (runLen != 0) lastRun = runLen;
        runLen = 0;
        vectors++;
        if (x !== IDLE_LVL || frame_done !== 1'b0 || x_valid !== 1'b0 || sb.size() != 0) begin
          miscompares++;
          $display("[TB] FAIL idle_line: x=%b x_valid=%b frame_done=%b pending=%0d, required x=%b x_valid=0 frame_done=0 pending=0",
                   x, x_valid, frame_done, sb.size(), IDLE_LVL);
          sb.delete();
        end
        expReady = (edgesSinceRelease > 0);
      end
      vectors++;
      if (din_ready !== expReady) begin
        miscompares++;
        $display("[TB] FAIL din_ready: got %b, required %b", din_ready, expReady);
      end
    end
  end

  task automatic pushFrame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      sb.push_back('{b: w[i], last: (i == 0) && (FLEN == W)});
    end
`ifdef SERIAL_PARITY_EN
    sb.push_back('{b: ^w, last: 1'b1});
`endif
  endtask

  // Presents w with din_valid high until the block is ready, then lets the
  // handshake edge pass. din_valid is left high for the caller to manage.
  task automatic sendWord(input logic [W-1:0] w);
    bit got;
    got = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      #1;
      if (din_ready === 1'b1) begin
        pushFrame(w);
        got = 1'b1;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake_timeout: din_ready=%b, required 1", din_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && x_valid === 1'b0) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: pending=%0d x_valid=%b, required 0 and 0", sb.size(), x_valid);
      sb.delete();
    end
  endtask

  task automatic doReset();
    din_valid = 1'b0;
    din = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    doneCount = 0;
    lastRun = 0;
    runLen = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din_valid = 1'b0;
    din = '0;
    #12;
    vectors++;
    if (x !== IDLE_LVL || x_valid !== 1'b0 || frame_done !== 1'b0 || din_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: x=%b x_valid=%b frame_done=%b din_ready=%b, required %b 0 0 0",
               x, x_valid, frame_done, din_ready, IDLE_LVL);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_release: din_ready=%b, required 1", din_ready);
    end
  endtask

  task automatic test_idle();
    doneCount = 0;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (doneCount != 0 || lastRun != 0) begin
      miscompares++;
      $display("[TB] FAIL idle_activity: frame_done pulses=%0d run=%0d, required 0 0", doneCount, lastRun);
    end
  endtask

  task automatic test_single_frame();
    doReset();
    sendWord(8'hA5);
    din_valid = 1'b0;
    waitDrain();
    vectors++;
    if (lastRun != FLEN || doneCount != 1) begin
      miscompares++;
      $display("[TB] FAIL single_frame_shape: run=%0d done=%0d, required run=%0d done=1", lastRun, doneCount, FLEN);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    sendWord(8'hA5);
    sendWord(8'h3C);
    din_valid = 1'b0;
    waitDrain();
    vectors++;
    if (lastRun != 2 * FLEN || doneCount != 2) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_shape: run=%0d done=%0d, required run=%0d done=2", lastRun, doneCount, 2 * FLEN);
    end
  endtask

  task automatic test_ignored_input();
    doReset();
    sendWord(8'hA5);
    din = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 8'h00;
    waitDrain();
    vectors++;
    if (lastRun != FLEN || doneCount != 1) begin
      miscompares++;
      $display("[TB] FAIL ignored_input_shape: run=%0d done=%0d, required run=%0d done=1", lastRun, doneCount, FLEN);
    end
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    sendWord(8'hA5);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    sb.delete();
    #1;
    vectors++;
    if (x !== IDLE_LVL || x_valid !== 1'b0 || din_ready !== 1'b0 || frame_done !== 1'b0 || doneCount != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_frame: x=%b x_valid=%b din_ready=%b frame_done=%b pulses=%0d, required %b 0 0 0 0",
               x, x_valid, din_ready, frame_done, doneCount, IDLE_LVL);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    runLen = 0;
    lastRun = 0;
    @(posedge clk);
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_mid_reset: din_ready=%b, required 1", din_ready);
    end
    sendWord(8'h0F);
    din_valid = 1'b0;
    waitDrain();
    vectors++;
    if (lastRun != FLEN || doneCount != 1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_frame: run=%0d done=%0d, required run=%0d done=1", lastRun, doneCount, FLEN);
    end
  endtask

  // Mixed words (odd/even parity, all-ones, all-zeros) sent back to back.
  task automatic test_patterns();
    logic [W-1:0] words [6];
    words = '{8'h07, 8'hA5, 8'hFF, 8'h00, 8'h81, 8'h5A};
    doReset();
    foreach (words[i]) sendWord(words[i]);
    din_valid = 1'b0;
    waitDrain();
    vectors++;
    if (lastRun != 6 * FLEN || doneCount != 6) begin
      miscompares++;
      $display("[TB] FAIL pattern_stream: run=%0d done=%0d, required run=%0d done=6", lastRun, doneCount, 6 * FLEN);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    runLen = 0;
    lastRun = 0;
    doneCount = 0;
    test_reset();
    test_idle();
    test_single_frame();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_frame();
    test_patterns();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
